pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game sequencer for the VGA Pong datapath. It owns paddle, ball and score state, applies player button inputs once per video frame, and sequences serve/play/point/game-over phases. It sits between the button/switch inputs of `top_vga` and the pixel renderer, which reads its position and score outputs as registered, frame-stable values.

## Interface
Parameters:
- `PADDLE_STEP`, 4: paddle pixels moved per frame.
- `SERVE_FRAMES`, 60: frames the ball is held at centre before play.
- `WIN_SCORE`, 9: score that ends the game.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-high.
- `frame_tick`  in  1  one-cycle pulse at start of vertical blanking.
- `sw`  in  3  `sw[0]` run (1) / pause (0). `sw[2:1]` ball speed select.
- `p1_up`, `p1_down`, `p2_up`, `p2_down`  in  1 each  raw button levels, asynchronous to `clk`.
- `paddle1_y`, `paddle2_y`  out  9  paddle top row.
- `ball_x`  out  10  ball left column.
- `ball_y`  out  9  ball top row.
- `score1`, `score2`  out  4  player scores.
- `state`  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=GAMEOVER.
- `frame_done`  out  1  one-cycle pulse after each processed `frame_tick`.

## Operation
- Geometry:
  - Screen is 640x480.
  - Paddle is 8x64. Paddle1 occupies x 16..23; paddle2 occupies x 616..623.
  - Ball is 8x8.
  - Paddle y range is 0..416. Ball y range is 0..472.
- Buttons:
  - Each button passes through a 2-flop synchronizer.
  - Buttons are sampled only on `frame_tick`.
  - Up moves the paddle by -`PADDLE_STEP`, down moves it by +`PADDLE_STEP`.
  - Both or neither pressed: no move.
  - The result is clamped to 0..416.
  - Paddles move in SERVE and in PLAY while running. They are frozen in IDLE, in GAMEOVER, and while paused.
- Ball speed per axis per frame is `sw[2:1]`+1 (1..4 px). Direction is held in flags `dx` (1=right) and `dy` (1=down).
- Next-position arithmetic is 11-bit signed, so underflow is detected rather than wrapped.
- Bounce and score rules, evaluated in PLAY against paddle positions before this frame's paddle move:
  - Vertical: next y < 0 sets y=0 and dy=1. Next y > 472 sets y=472 and dy=0.
  - Left paddle, dx=0: if next x <= 24 and the ball overlaps the paddle (`by+8 > p1y` and `by < p1y+64`), set x=24 and dx=1. Otherwise, next x <= 0 is a point to player 2.
  - Right paddle, dx=1: if next x >= 608 with overlap on paddle2, set x=608 and dx=0. Otherwise, next x >= 632 is a point to player 1.
  - Vertical bounce and paddle bounce in the same frame are both applied.
- State machine, transitions taken only on `frame_tick`:
  - IDLE:
    - Ball at (316,236), paddles at 208, scores cleared.
    - `sw[0]`=1 loads the serve counter with `SERVE_FRAMES` and goes to SERVE.
  - SERVE:
    - Ball held at centre; the counter decrements each frame.
    - At 0, go to PLAY. The counter pauses while `sw[0]`=0.
  - PLAY:
    - `sw[0]`=0 freezes everything and the state stays PLAY.
    - On a point, the scorer's score increments.
    - If it equals `WIN_SCORE`, go to GAMEOVER. Otherwise recentre the ball, set dx toward the conceding player, reload the counter, and go to SERVE.
    - dy is kept across points.
  - GAMEOVER: everything is frozen. `sw[0]`=0 goes to IDLE.
- Reset values: state IDLE, paddles 208, ball (316,236), dx=1, dy=1, scores 0, `frame_done` 0, serve counter 0.

## Timing
- `frame_tick` is high in cycle t. All registers update at the end of t, new outputs are visible in t+1, and `frame_done` is high in t+1 only.
- Outputs are otherwise constant for the whole frame.
- A button level must be stable for at least 3 `clk` cycles before `frame_tick` to be counted.
- `frame_tick` while `rst` is high is ignored.
- `rst` asserted mid-frame or mid-game returns all outputs to reset values immediately, independent of `clk`.
- Back-to-back `frame_tick` (consecutive cycles): each is processed; `frame_done` stays high for 2 cycles.

## Test plan
- Reset, `sw`=3'b001, 1 tick -> state=SERVE. After 60 more ticks -> state=PLAY. Ball still at (316,236) until the first PLAY update.
- PLAY, speed 0, dx=1, dy=1 -> one tick gives ball (317,237). Speed 3 (`sw[2:1]`=3) -> (321,241).
- `p1_up` held with paddle1_y=2 -> next tick 0. Both p2 buttons held -> paddle2_y unchanged. Paused (`sw[0]`=0) -> no motion over 5 ticks.
- Ball (25,100), dx=0, paddle1_y=80, speed 1 -> x=24, dx=1. Same with paddle1_y=300 -> eventual miss: score2+1, state=SERVE, ball centred, dx=0.
- score1=8, player 1 scores -> score1=9, state=GAMEOVER. `sw[0]`=0 tick -> IDLE with scores 0.
- Assert `rst` mid-PLAY between clock edges -> all outputs at reset values before the next `clk` edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game sequencer for the VGA Pong datapath.
// Owns paddle, ball and score state. Button inputs are synchronized and applied once per
// frame_tick, and the serve/play/point/game-over phases are sequenced here.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse at start of vertical blanking
//   sw[0]               run (1) / pause (0); sw[2:1] ball speed select (speed = sw[2:1] + 1)
//   p1_up .. p2_down    raw asynchronous button levels
//   paddle1_y/2_y       paddle top rows
//   ball_x, ball_y      ball top-left corner
//   score1, score2      player scores
//   state               0=IDLE 1=SERVE 2=PLAY 3=GAMEOVER
//   frame_done          one-cycle pulse in the cycle after each processed frame_tick
module pong_game_ctrl #(
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [2:0] sw,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [8:0] paddle1_y,
    output logic [8:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state,
    output logic       frame_done
);

    localparam logic [9:0]         CentreX    = 10'd316;
    localparam logic [8:0]         CentreY    = 9'd236;
    localparam logic [8:0]         PaddleHome = 9'd208;
    localparam logic signed [10:0] Zero       = 11'sd0;
    localparam logic signed [10:0] PaddleMax  = 11'sd416;
    localparam logic signed [10:0] BallMaxY   = 11'sd472;
    localparam logic signed [10:0] LeftFace   = 11'sd24;
    localparam logic signed [10:0] RightFace  = 11'sd608;
    localparam logic signed [10:0] RightGoal  = 11'sd632;
    localparam logic signed [10:0] Step       = 11'(PADDLE_STEP);
    localparam logic [15:0]        ServeLoad  = 16'(SERVE_FRAMES);
    localparam logic [3:0]         WinScore   = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StServe    = 2'd1,
        StPlay     = 2'd2,
        StGameover = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  p1_q, p1_d, p2_q, p2_d;
    logic [9:0]  bx_q, bx_d;
    logic [8:0]  by_q, by_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [3:0]  s1_q, s1_d, s2_q, s2_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q;
    logic [3:0]  btn_meta, btn_sync;   // {p1_up, p1_down, p2_up, p2_down}

    // Next-step ball arithmetic in 11-bit signed so a left-edge underflow stays negative.
    logic signed [10:0] spd, bx_s, by_s, nx, ny;
    logic [10:0]        by_u, p1_u, p2_u;
    logic               ov1, ov2, pt1, pt2, dx_nx, dy_nx;
    logic [9:0]         bx_nx;
    logic [8:0]         by_nx;

    function automatic logic [8:0] paddle_next(input logic [8:0] cur, input logic up,
                                               input logic dn);
        logic signed [10:0] p;
        p = signed'({2'b00, cur});
        if (up && !dn)      p = p - Step;
        else if (dn && !up) p = p + Step;
        if (p < Zero)           p = Zero;
        else if (p > PaddleMax) p = PaddleMax;
        return p[8:0];
    endfunction

    assign spd  = signed'({8'd0, {1'b0, sw[2:1]} + 3'd1});
    assign bx_s = signed'({1'b0, bx_q});
    assign by_s = signed'({2'b00, by_q});
    assign nx   = dx_q ? bx_s + spd : bx_s - spd;
    assign ny   = dy_q ? by_s + spd : by_s - spd;
    assign by_u = {2'b00, by_q};
    assign p1_u = {2'b00, p1_q};
    assign p2_u = {2'b00, p2_q};
    // Overlap uses the paddle positions from before this frame's move.
    assign ov1  = (by_u + 11'd8 > p1_u) && (by_u < p1_u + 11'd64);
    assign ov2  = (by_u + 11'd8 > p2_u) && (by_u < p2_u + 11'd64);

    always_comb begin
        by_nx = ny[8:0];
        dy_nx = dy_q;
        if (ny < Zero) begin
            by_nx = '0;
            dy_nx = 1'b1;
        end else if (ny > BallMaxY) begin
            by_nx = BallMaxY[8:0];
            dy_nx = 1'b0;
        end
        bx_nx = nx[9:0];
        dx_nx = dx_q;
        pt1   = 1'b0;
        pt2   = 1'b0;
        if (!dx_q) begin
            if (nx <= LeftFace && ov1) begin
                bx_nx = LeftFace[9:0];
                dx_nx = 1'b1;
            end else if (nx <= Zero) begin
                pt2 = 1'b1;
            end
        end else begin
            if (nx >= RightFace && ov2) begin
                bx_nx = RightFace[9:0];
                dx_nx = 1'b0;
            end else if (nx >= RightGoal) begin
                pt1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            unique case (state_q)
                StIdle: begin
                    bx_d = CentreX;
                    by_d = CentreY;
                    p1_d = PaddleHome;
                    p2_d = PaddleHome;
                    s1_d = '0;
                    s2_d = '0;
                    if (sw[0]) begin
                        cnt_d   = ServeLoad;
                        state_d = StServe;
                    end
                end
                StServe: if (sw[0]) begin
                    p1_d = paddle_next(p1_q, btn_sync[3], btn_sync[2]);
                    p2_d = paddle_next(p2_q, btn_sync[1], btn_sync[0]);
                    // The frame that counts down to zero is the one that starts play.
                    if (cnt_q <= 16'd1) begin
                        cnt_d   = '0;
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                StPlay: if (sw[0]) begin
                    p1_d = paddle_next(p1_q, btn_sync[3], btn_sync[2]);
                    p2_d = paddle_next(p2_q, btn_sync[1], btn_sync[0]);
                    dy_d = dy_nx;
                    if (pt1 || pt2) begin
                        if (pt1) s1_d = s1_q + 4'd1;
                        else     s2_d = s2_q + 4'd1;
                        if (s1_d == WinScore || s2_d == WinScore) begin
                            state_d = StGameover;
                        end else begin
                            bx_d    = CentreX;
                            by_d    = CentreY;
                            dx_d    = pt1;   // serve toward the player who conceded
                            cnt_d   = ServeLoad;
                            state_d = StServe;
                        end
                    end else begin
                        bx_d = bx_nx;
                        by_d = by_nx;
                        dx_d = dx_nx;
                    end
                end
                StGameover: if (!sw[0]) begin
                    bx_d    = CentreX;
                    by_d    = CentreY;
                    p1_d    = PaddleHome;
                    p2_d    = PaddleHome;
                    s1_d    = '0;
                    s2_d    = '0;
                    state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            state_q  <= StIdle;
            p1_q     <= PaddleHome;
            p2_q     <= PaddleHome;
            bx_q     <= CentreX;
            by_q     <= CentreY;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            btn_meta <= {p1_up, p1_down, p2_up, p2_down};
            btn_sync <= btn_meta;
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            done_q   <= frame_tick;
        end
    end

    assign paddle1_y  = p1_q;
    assign paddle2_y  = p2_q;
    assign ball_x     = bx_q;
    assign ball_y     = by_q;
    assign score1     = s1_q;
    assign score2     = s2_q;
    assign state      = state_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, hand-written multi-cycle
// sequences, then a randomized game checked frame by frame against a behavioural model.
module tb_pong_game_ctrl;

    localparam int Step  = 4;
    localparam int Serve = 60;
    localparam int Win   = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [2:0] sw;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [8:0] paddle1_y, paddle2_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score1, score2;
    logic [1:0] state;
    logic       frame_done;

    pong_game_ctrl #(
        .PADDLE_STEP (Step),
        .SERVE_FRAMES(Serve),
        .WIN_SCORE   (Win)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .sw        (sw),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .paddle1_y (paddle1_y),
        .paddle2_y (paddle2_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score1    (score1),
        .score2    (score2),
        .state     (state),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural game model: plain integers, state 0..3 as in the output encoding.
    int m_st, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_cnt;

    typedef struct {
        logic [2:0] sw;
        logic [3:0] btn;   // {p1_up, p1_down, p2_up, p2_down}
        int         n;
        int         e_st;
        int         e_p1;
        int         e_p2;
        int         e_bx;
        int         e_by;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0;
    endtask

    function automatic int pmove(input int p, input bit up, input bit dn);
        int r;
        r = p;
        if (up && !dn) r = r - Step;
        if (dn && !up) r = r + Step;
        if (r < 0)   r = 0;
        if (r > 416) r = 416;
        return r;
    endfunction

    task automatic model_frame(input logic [2:0] s, input logic [3:0] b);
        int  spd, nx, ny, scorer;
        bit  run;
        run = s[0];
        spd = int'(s[2:1]) + 1;
        if (m_st == 0) begin
            m_bx = 316; m_by = 236; m_p1 = 208; m_p2 = 208; m_s1 = 0; m_s2 = 0;
            if (run) begin
                m_cnt = Serve;
                m_st  = 1;
            end
        end else if (m_st == 1) begin
            if (run) begin
                m_p1 = pmove(m_p1, b[3], b[2]);
                m_p2 = pmove(m_p2, b[1], b[0]);
                if (m_cnt <= 1) begin
                    m_cnt = 0;
                    m_st  = 2;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else if (m_st == 2) begin
            if (run) begin
                nx = (m_dx == 1) ? m_bx + spd : m_bx - spd;
                ny = (m_dy == 1) ? m_by + spd : m_by - spd;
                if (ny < 0) begin
                    ny = 0; m_dy = 1;
                end else if (ny > 472) begin
                    ny = 472; m_dy = 0;
                end
                scorer = 0;
                if (m_dx == 0) begin
                    if (nx <= 24 && m_by + 8 > m_p1 && m_by < m_p1 + 64) begin
                        nx = 24; m_dx = 1;
                    end else if (nx <= 0) begin
                        scorer = 2;
                    end
                end else begin
                    if (nx >= 608 && m_by + 8 > m_p2 && m_by < m_p2 + 64) begin
                        nx = 608; m_dx = 0;
                    end else if (nx >= 632) begin
                        scorer = 1;
                    end
                end
                m_p1 = pmove(m_p1, b[3], b[2]);
                m_p2 = pmove(m_p2, b[1], b[0]);
                if (scorer == 0) begin
                    m_bx = nx; m_by = ny;
                end else begin
                    if (scorer == 1) m_s1++;
                    else             m_s2++;
                    if (m_s1 == Win || m_s2 == Win) begin
                        m_st = 3;
                    end else begin
                        m_bx = 316; m_by = 236; m_dx = (scorer == 1) ? 1 : 0;
                        m_cnt = Serve; m_st = 1;
                    end
                end
            end
        end else begin
            if (!run) begin
                m_bx = 316; m_by = 236; m_p1 = 208; m_p2 = 208; m_s1 = 0; m_s2 = 0;
                m_st = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("state",     int'(state),     m_st);
        chk("paddle1_y", int'(paddle1_y), m_p1);
        chk("paddle2_y", int'(paddle2_y), m_p2);
        chk("ball_x",    int'(ball_x),    m_bx);
        chk("ball_y",    int'(ball_y),    m_by);
        chk("score1",    int'(score1),    m_s1);
        chk("score2",    int'(score2),    m_s2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"},      int'(state),      0);
        chk({tag, "_paddle1_y"},  int'(paddle1_y),  208);
        chk({tag, "_paddle2_y"},  int'(paddle2_y),  208);
        chk({tag, "_ball_x"},     int'(ball_x),     316);
        chk({tag, "_ball_y"},     int'(ball_y),     236);
        chk({tag, "_score1"},     int'(score1),     0);
        chk({tag, "_score2"},     int'(score2),     0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_frame(input logic [2:0] s, input logic [3:0] b);
        sw = s;
        {p1_up, p1_down, p2_up, p2_down} = b;
        repeat (3) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        model_frame(s, b);
        chk("frame_done_high", int'(frame_done), 1);
        check_model();
        @(posedge clk);
        #1 chk("frame_done_low", int'(frame_done), 0);
    endtask

    initial begin
        logic [2:0] rs;
        logic [3:0] rb;

        tbl[0] = '{3'b001, 4'b0000, 1,  1, 208, 208, 316, 236};
        tbl[1] = '{3'b001, 4'b1000, 52, 1, 0,   208, 316, 236};
        tbl[2] = '{3'b001, 4'b1000, 8,  2, 0,   208, 316, 236};
        tbl[3] = '{3'b001, 4'b0011, 1,  2, 0,   208, 317, 237};
        tbl[4] = '{3'b000, 4'b0100, 5,  2, 0,   208, 317, 237};
        tbl[5] = '{3'b111, 4'b0000, 1,  2, 0,   208, 321, 241};
        tbl[6] = '{3'b001, 4'b0100, 2,  2, 8,   208, 323, 243};

        rst = 1'b1;
        frame_tick = 1'b0;
        sw = 3'b000;
        {p1_up, p1_down, p2_up, p2_down} = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset("reset");

        // A frame_tick during reset must be ignored.
        sw = 3'b001;
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 check_reset("tick_in_reset");

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < tbl[i].n; k++) do_frame(tbl[i].sw, tbl[i].btn);
            chk($sformatf("vec%0d_state", i), int'(state),     tbl[i].e_st);
            chk($sformatf("vec%0d_p1", i),    int'(paddle1_y), tbl[i].e_p1);
            chk($sformatf("vec%0d_p2", i),    int'(paddle2_y), tbl[i].e_p2);
            chk($sformatf("vec%0d_bx", i),    int'(ball_x),    tbl[i].e_bx);
            chk($sformatf("vec%0d_by", i),    int'(ball_y),    tbl[i].e_by);
        end

        // A button raised only one cycle before frame_tick is not yet through the synchronizer.
        do_frame(3'b001, 4'b0000);
        sw = 3'b001;
        {p1_up, p1_down, p2_up, p2_down} = 4'b0100;
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        model_frame(3'b001, 4'b0000);
        chk("late_button_p1", int'(paddle1_y), 8);
        check_model();
        @(posedge clk);
        #1 do_frame(3'b001, 4'b0100);
        chk("settled_button_p1", int'(paddle1_y), 12);

        // Back-to-back ticks: both processed, frame_done high for two cycles.
        sw = 3'b001;
        {p1_up, p1_down, p2_up, p2_down} = 4'b0000;
        repeat (3) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 model_frame(3'b001, 4'b0000);
        chk("b2b_done_1", int'(frame_done), 1);
        check_model();
        @(posedge clk);
        #1 frame_tick = 1'b0;
        model_frame(3'b001, 4'b0000);
        chk("b2b_done_2", int'(frame_done), 1);
        check_model();
        @(posedge clk);
        #1 chk("b2b_done_low", int'(frame_done), 0);

        // Asynchronous reset between clock edges, mid-PLAY.
        #3 rst = 1'b1;
        #1 check_reset("async_reset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized game until someone wins.
        for (int f = 0; f < 9000 && m_st != 3; f++) begin
            rs = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) != 0)};
            rb = 4'($urandom);
            do_frame(rs, rb);
        end
        chk("gameover_state", int'(state), 3);
        chk("winner_score", (score1 > score2) ? int'(score1) : int'(score2), Win);
        for (int k = 0; k < 3; k++) do_frame(3'b111, 4'b1010);
        do_frame(3'b000, 4'b0000);
        chk("idle_after_gameover", int'(state), 0);
        chk("idle_score1", int'(score1), 0);
        chk("idle_score2", int'(score2), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
